// File: rtl/pc_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
//   Shared types and constants for the PC / instruction-fetch sequencer:
//   FSM state encoding, fault cause codes, default width and reset PC, and a
//   small alignment helper used by the next-PC calculator.
// -----------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

  localparam int unsigned CPU_WIDTH    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_BUS_ERR  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_e;

  // Instruction addresses must be word aligned; only the two LSBs matter.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_if
//   Instruction-memory port: a valid/ready request channel carrying the fetch
//   address and a valid/ready response channel carrying the instruction word
//   plus a bus-error flag.
//   master : fetch controller (drives req_valid, req_addr, rsp_ready)
//   slave  : instruction memory (drives req_ready, rsp_valid, rsp_data, rsp_err)
// -----------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/pc_fetch_ctrl_next_calc.sv
// -----------------------------------------------------------------------------
// pc_next_calc
//   Combinational next-PC selection for the retiring instruction, plus the
//   misalignment check on the chosen target.
//   Priority: trap > jal > jalr > sequential. All adds wrap modulo 2^XLEN.
//   Ports:
//     i_pc, i_imm, i_data_rs1, i_trap_vec   : operands
//     i_trap_en, i_jal_en, i_jalr_en        : redirect selects
//     o_next_pc                             : selected target
//     o_misaligned                          : target not word aligned
// -----------------------------------------------------------------------------
module pc_next_calc
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = CPU_WIDTH
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_data_rs1,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_trap_en,
  input  logic            i_jal_en,
  input  logic            i_jalr_en,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_jal_pc;
  logic [XLEN-1:0] w_jalr_pc;

  assign w_seq_pc  = i_pc + XLEN'(4);
  assign w_jal_pc  = i_pc + i_imm;
  // jalr target has bit 0 forced low; bit 1 is left for the alignment check.
  assign w_jalr_pc = (i_data_rs1 + i_imm) & ~XLEN'(1);

  always_comb begin
    o_next_pc = w_seq_pc;
    if (i_trap_en)      o_next_pc = i_trap_vec;
    else if (i_jal_en)  o_next_pc = w_jal_pc;
    else if (i_jalr_en) o_next_pc = w_jalr_pc;
  end

  assign o_misaligned = !is_word_aligned(o_next_pc[1:0]);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   PC register and instruction-fetch sequencer for the multi-cycle core.
//   One fetch per instruction over the imem valid/ready port; the fetched word
//   is held on inst while the core executes it. The PC advances only when the
//   instruction retires (exec_done), following trap/jal/jalr redirects.
//   Bus errors, misaligned targets and response timeouts latch a sticky fault
//   that halts fetching until reset.
//   Ports:
//     clk, rstn                  : clock, async active-low reset
//     imem (master)              : instruction memory request/response port
//     inst, inst_valid           : latched instruction, live in EXEC
//     exec_done                  : current instruction retires this cycle
//     jal_jump_en, jalr_jump_en  : jump redirects (sampled with exec_done)
//     imm, data_rs1              : jump operands
//     trap_en, trap_vec          : trap redirect and target
//     pc                         : current PC (also the fetch address)
//     fetch_fault, fault_cause   : sticky fault flag and its cause code
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = CPU_WIDTH,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned      TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  pc_fetch_ctrl_if.master        imem,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  input  logic                   exec_done,
  input  logic                   jal_jump_en,
  input  logic                   jalr_jump_en,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        data_rs1,
  input  logic                   trap_en,
  input  logic [XLEN-1:0]        trap_vec,
  output logic [XLEN-1:0]        pc,
  output logic                   fetch_fault,
  output logic [1:0]             fault_cause
);

  // The wait counter only has to reach TIMEOUT-1.
  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           r_state;
  logic [XLEN-1:0]  r_pc;
  logic [31:0]      r_inst;
  logic             r_req_valid;
  logic             r_rsp_ready;
  logic             r_inst_valid;
  logic             r_fault;
  cause_e           r_cause;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN-1:0]  w_next_pc;
  logic             w_misaligned;

  pc_next_calc #(
    .XLEN (XLEN)
  ) u_next_calc (
    .i_pc         (r_pc),
    .i_imm        (imm),
    .i_data_rs1   (data_rs1),
    .i_trap_vec   (trap_vec),
    .i_trap_en    (trap_en),
    .i_jal_en     (jal_jump_en),
    .i_jalr_en    (jalr_jump_en),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  // All handshake outputs are flops set on the transition into the state that
  // owns them, so the port sees no combinational path from any input.
  // NOTE: state uses non-blocking assignments so every branch reads the
  //       pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_req_valid  <= 1'b0;
      r_rsp_ready  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_cause      <= CAUSE_NONE;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
        end

        // Address is r_pc, which only moves on retire, so it is stable
        // for as long as the request waits.
        ST_REQ: begin
          if (imem.req_ready) begin
            r_state     <= ST_WAIT_RSP;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_cnt       <= '0;
          end
        end

        // A response arriving on the last allowed cycle takes precedence
        // over the timeout.
        ST_WAIT_RSP: begin
          if (imem.rsp_valid) begin
            r_rsp_ready <= 1'b0;
            r_cnt       <= '0;
            if (imem.rsp_err) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_cause <= CAUSE_BUS_ERR;
            end else begin
              r_state      <= ST_EXEC;
              r_inst       <= imem.rsp_data;
              r_inst_valid <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_rsp_ready <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_FAULT;
            r_fault     <= 1'b1;
            r_cause     <= CAUSE_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // Redirect inputs matter only in the retire cycle; a misaligned
        // target leaves the PC pointing at the instruction that caused it.
        ST_EXEC: begin
          if (exec_done) begin
            r_inst_valid <= 1'b0;
            if (!w_misaligned) begin
              r_pc        <= w_next_pc;
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_cause <= CAUSE_MISALIGN;
            end
          end
        end

        ST_FAULT: begin
          r_state <= ST_FAULT;
        end

        default: begin
          r_state      <= ST_FAULT;
          r_req_valid  <= 1'b0;
          r_rsp_ready  <= 1'b0;
          r_inst_valid <= 1'b0;
          r_fault      <= 1'b1;
        end
      endcase
    end
  end

  assign imem.req_valid = r_req_valid;
  assign imem.req_addr  = r_pc;
  assign imem.rsp_ready = r_rsp_ready;
  assign inst           = r_inst;
  assign inst_valid     = r_inst_valid;
  assign pc             = r_pc;
  assign fetch_fault    = r_fault;
  assign fault_cause    = r_cause;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Directed bench for pc_fetch_ctrl (TIMEOUT = 4). Each step drives one
//   cycle of inputs on the falling edge and compares the registered outputs
//   against hand-computed values. A vector table covers normal fetch/retire,
//   stalls, redirects, response delay and timeout; short hand sequences cover
//   bus error, misaligned target and reset in the middle of a fetch.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exec_done;
  logic        jal_jump_en;
  logic        jalr_jump_en;
  logic [31:0] imm;
  logic [31:0] data_rs1;
  logic        trap_en;
  logic [31:0] trap_vec;
  logic [31:0] pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_ctrl_if #(.XLEN(32)) imem ();

  pc_fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (PC0),
    .TIMEOUT  (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem         (imem),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .exec_done    (exec_done),
    .jal_jump_en  (jal_jump_en),
    .jalr_jump_en (jalr_jump_en),
    .imm          (imm),
    .data_rs1     (data_rs1),
    .trap_en      (trap_en),
    .trap_vec     (trap_vec),
    .pc           (pc),
    .fetch_fault  (fetch_fault),
    .fault_cause  (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl   = {req_ready, rsp_valid, rsp_err, exec_done, jal, jalr, trap}
  // flags = {req_valid, rsp_ready, inst_valid, fetch_fault}
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] data;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] tvec;
    logic [3:0]  e_flags;
    logic [1:0]  e_cause;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] c, input logic [31:0] d,
                              input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] tv, input logic [3:0] f,
                              input logic [1:0] cs, input logic [31:0] p,
                              input logic [31:0] ins);
    vec_t v;
    v.ctl = c; v.data = d; v.imm = im; v.rs1 = r1; v.tvec = tv;
    v.e_flags = f; v.e_cause = cs; v.e_pc = p; v.e_inst = ins;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ef,
                            input logic [1:0] ec, input logic [31:0] epc,
                            input logic [31:0] einst);
    check({tag, ".req_valid"},  32'(imem.req_valid), 32'(ef[3]));
    check({tag, ".req_addr"},   imem.req_addr,        epc);
    check({tag, ".rsp_ready"},  32'(imem.rsp_ready), 32'(ef[2]));
    check({tag, ".inst_valid"}, 32'(inst_valid),     32'(ef[1]));
    check({tag, ".fetch_fault"},32'(fetch_fault),    32'(ef[0]));
    check({tag, ".fault_cause"},32'(fault_cause),    32'(ec));
    check({tag, ".pc"},         pc,                  epc);
    check({tag, ".inst"},       inst,                einst);
  endtask

  task automatic drive(input logic [6:0] c, input logic [31:0] d,
                       input logic [31:0] im, input logic [31:0] r1,
                       input logic [31:0] tv);
    imem.req_ready = c[6];
    imem.rsp_valid = c[5];
    imem.rsp_err   = c[4];
    exec_done      = c[3];
    jal_jump_en    = c[2];
    jalr_jump_en   = c[1];
    trap_en        = c[0];
    imem.rsp_data  = d;
    imm            = im;
    data_rs1       = r1;
    trap_vec       = tv;
  endtask

  // One cycle: drive inputs after the falling edge, check the state outputs.
  task automatic step(input string tag, input logic [6:0] c,
                      input logic [31:0] d, input logic [31:0] im,
                      input logic [31:0] r1, input logic [31:0] tv,
                      input logic [3:0] ef, input logic [1:0] ec,
                      input logic [31:0] epc, input logic [31:0] einst);
    @(negedge clk);
    drive(c, d, im, r1, tv);
    #1;
    check_outs(tag, ef, ec, epc, einst);
  endtask

  // Reset for one cycle, check reset values, release and check BOOT idle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    drive(7'b0, '0, '0, '0, '0);
    rstn = 1'b0;
    #1;
    check_outs({tag, ".rst"}, 4'b0000, 2'd0, PC0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_outs({tag, ".boot"}, 4'b0000, 2'd0, PC0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    drive(7'b0, '0, '0, '0, '0);

    // REQ stall, fetch/retire, redirects, delayed response, timeout.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(7'b0000000, 0, 0, 0, 0, 4'b1000, 0, PC0, 0));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, PC0, 0));
    vecs.push_back(mk(7'b0100000, 32'h1111_0001, 0, 0, 0, 4'b0100, 0, PC0, 0));
    vecs.push_back(mk(7'b0001000, 0, 0, 0, 0, 4'b0010, 0, PC0, 32'h1111_0001));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, 32'h8000_0004, 32'h1111_0001));
    vecs.push_back(mk(7'b0100000, 32'h1111_0002, 0, 0, 0, 4'b0100, 0, 32'h8000_0004, 32'h1111_0001));
    // Redirects without exec_done: stays in EXEC, pc unchanged.
    vecs.push_back(mk(7'b0000101, 0, 32'h100, 0, 0, 4'b0010, 0, 32'h8000_0004, 32'h1111_0002));
    vecs.push_back(mk(7'b0001100, 0, 32'hC, 0, 0, 4'b0010, 0, 32'h8000_0004, 32'h1111_0002));
    // exec_done + trap outside EXEC: ignored.
    vecs.push_back(mk(7'b1001001, 0, 0, 0, 32'h400, 4'b1000, 0, 32'h8000_0010, 32'h1111_0002));
    vecs.push_back(mk(7'b0100000, 32'h1111_0003, 0, 0, 0, 4'b0100, 0, 32'h8000_0010, 32'h1111_0002));
    vecs.push_back(mk(7'b0001100, 0, 32'hFFFF_FFF0, 0, 0, 4'b0010, 0, 32'h8000_0010, 32'h1111_0003));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, PC0, 32'h1111_0003));
    vecs.push_back(mk(7'b0100000, 32'h1111_0004, 0, 0, 0, 4'b0100, 0, PC0, 32'h1111_0003));
    vecs.push_back(mk(7'b0001010, 0, 0, 32'h8000_0101, 0, 4'b0010, 0, PC0, 32'h1111_0004));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, 32'h8000_0100, 32'h1111_0004));
    vecs.push_back(mk(7'b0100000, 32'h1111_0005, 0, 0, 0, 4'b0100, 0, 32'h8000_0100, 32'h1111_0004));
    // trap and jal together: trap wins.
    vecs.push_back(mk(7'b0001101, 0, 32'h4, 0, 32'h8000_0200, 4'b0010, 0, 32'h8000_0100, 32'h1111_0005));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, 32'h8000_0200, 32'h1111_0005));
    vecs.push_back(mk(7'b0100000, 32'h1111_0006, 0, 0, 0, 4'b0100, 0, 32'h8000_0200, 32'h1111_0005));
    // jalr sum wraps past 2^32.
    vecs.push_back(mk(7'b0001010, 0, 32'h8, 32'hFFFF_FFFC, 0, 4'b0010, 0, 32'h8000_0200, 32'h1111_0006));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, 32'h4, 32'h1111_0006));
    // Response on the 4th WAIT cycle beats the timeout.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(7'b0000000, 0, 0, 0, 0, 4'b0100, 0, 32'h4, 32'h1111_0006));
    vecs.push_back(mk(7'b0100000, 32'h1111_0007, 0, 0, 0, 4'b0100, 0, 32'h4, 32'h1111_0006));
    vecs.push_back(mk(7'b0001000, 0, 0, 0, 0, 4'b0010, 0, 32'h4, 32'h1111_0007));
    vecs.push_back(mk(7'b1000000, 0, 0, 0, 0, 4'b1000, 0, 32'h8, 32'h1111_0007));
    // No response for 4 WAIT cycles: timeout fault.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(7'b0000000, 0, 0, 0, 0, 4'b0100, 0, 32'h8, 32'h1111_0007));
    vecs.push_back(mk(7'b1100000, 0, 0, 0, 0, 4'b0001, 2'd3, 32'h8, 32'h1111_0007));
    vecs.push_back(mk(7'b0001100, 0, 32'h4, 0, 0, 4'b0001, 2'd3, 32'h8, 32'h1111_0007));

    do_reset("init");
    foreach (vecs[i])
      step($sformatf("t%0d", i), vecs[i].ctl, vecs[i].data, vecs[i].imm,
           vecs[i].rs1, vecs[i].tvec, vecs[i].e_flags, vecs[i].e_cause,
           vecs[i].e_pc, vecs[i].e_inst);

    // Bus error on response.
    do_reset("buserr");
    step("be0", 7'b1000000, 0, 0, 0, 0, 4'b1000, 0, PC0, 0);
    step("be1", 7'b0110000, 32'hDEAD_BEEF, 0, 0, 0, 4'b0100, 0, PC0, 0);
    step("be2", 7'b1100000, 0, 0, 0, 0, 4'b0001, 2'd1, PC0, 0);
    step("be3", 7'b1000000, 0, 0, 0, 0, 4'b0001, 2'd1, PC0, 0);

    // Misaligned jal target.
    do_reset("misal");
    step("ma0", 7'b1000000, 0, 0, 0, 0, 4'b1000, 0, PC0, 0);
    step("ma1", 7'b0100000, 32'h1111_0008, 0, 0, 0, 4'b0100, 0, PC0, 0);
    step("ma2", 7'b0001100, 0, 32'h2, 0, 0, 4'b0010, 0, PC0, 32'h1111_0008);
    step("ma3", 7'b1000000, 0, 0, 0, 0, 4'b0001, 2'd2, PC0, 32'h1111_0008);
    step("ma4", 7'b0001000, 0, 0, 0, 0, 4'b0001, 2'd2, PC0, 32'h1111_0008);

    // Reset pulse in WAIT_RSP, then a stale response while in REQ.
    do_reset("midrst");
    step("mr0", 7'b1000000, 0, 0, 0, 0, 4'b1000, 0, PC0, 0);
    step("mr1", 7'b0100000, 32'h1111_000A, 0, 0, 0, 4'b0100, 0, PC0, 0);
    step("mr2", 7'b0001000, 0, 0, 0, 0, 4'b0010, 0, PC0, 32'h1111_000A);
    step("mr3", 7'b1000000, 0, 0, 0, 0, 4'b1000, 0, 32'h8000_0004, 32'h1111_000A);
    step("mr4", 7'b0000000, 0, 0, 0, 0, 4'b0100, 0, 32'h8000_0004, 32'h1111_000A);
    #2;
    rstn = 1'b0;
    #1;
    check_outs("mr.async", 4'b0000, 2'd0, PC0, 32'h0);
    @(negedge clk);
    drive(7'b0100000, 32'hBAD0_BAD0, 0, 0, 0);
    rstn = 1'b1;
    #1;
    check_outs("mr.boot", 4'b0000, 2'd0, PC0, 32'h0);
    step("mr5", 7'b0100000, 32'hBAD0_BAD0, 0, 0, 0, 4'b1000, 0, PC0, 0);
    step("mr6", 7'b0100000, 32'hBAD0_BAD0, 0, 0, 0, 4'b1000, 0, PC0, 0);
    step("mr7", 7'b1100000, 32'hBAD0_BAD0, 0, 0, 0, 4'b1000, 0, PC0, 0);
    step("mr8", 7'b0100000, 32'h1111_000B, 0, 0, 0, 4'b0100, 0, PC0, 0);
    step("mr9", 7'b0001000, 0, 0, 0, 0, 4'b0010, 0, PC0, 32'h1111_000B);
    step("mr10", 7'b0000000, 0, 0, 0, 0, 4'b1000, 0, 32'h8000_0004, 32'h1111_000B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
